dmux_addr_seq: RTL and testbench

Address sequencer that sits directly upstream of the 1-to-2 address demultiplexer. On a start request it walks an address range from a programmable base, presenting one address per accepted transfer. It drives the demux's select so that consecutive bursts alternate between output 1 and output 2 (ping-pong banks). A valid/ready handshake lets the downstream consumer stall the stream.

---
 rtl/dmux_pkg.sv | 18 +
 rtl/dmux_burst_cnt.sv | 33 +++
 rtl/dmux_addr_seq.sv | 137 +++++++++++++
 tb/tb_dmux_addr_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared definitions for the address demux and its upstream sequencer:
// FSM states, default widths and the bank-select encoding.
package dmux_pkg;

  localparam int DEF_A = 8;
  localparam int DEF_D = 8;

  // Bank select encoding seen by the demux: 1 steers to out1, 0 to out2.
  localparam logic SEL_OUT1 = 1'b1;
  localparam logic SEL_OUT2 = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmux_burst_cnt.sv
// BURST-modulo transfer counter; wrap strobes on the accept that completes a burst.
module dmux_burst_cnt
  import dmux_pkg::*;
#(
  parameter int W     = DEF_A,
  parameter int BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [W-1:0] LAST = W'(BURST - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt;

  // Clear has priority so a reload never produces a stray toggle.
  assign wrap = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/dmux_addr_seq.sv
// Address sequencer for the 1-to-2 address demux: walks base..base+len-1 and ping-pongs sel every BURST accepts.
// Optional macro DMUX_ADDR_SEQ_LOOP_EN: restart from base on the last accept and run until stop.
module dmux_addr_seq
  import dmux_pkg::*;
#(
  parameter int A     = DEF_A,
  parameter int D     = DEF_D,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [A-1:0] base,
  input  logic [A-1:0] len,
  input  logic         stop,
  output logic [A-1:0] a,
  output logic         sel,
  output logic         valid,
  input  logic         ready,
  output logic         busy,
  output logic         done
);

  localparam logic [A-1:0] ONE = A'(1);

  if (A < 1 || D < 1 || BURST < 1 || BURST > (2**A) - 1) begin : g_param_chk
    $error("dmux_addr_seq: illegal A/D/BURST parameter set");
  end

  state_t       state;
  logic [A-1:0] len_q;
  logic [A-1:0] count;
  logic         accept;
  logic         run_acc;
  logic         last_xfer;
  logic         burst_clr;
  logic         burst_wrap;
`ifdef DMUX_ADDR_SEQ_LOOP_EN
  logic [A-1:0] base_q;
`endif

  assign accept    = valid && ready;
  // stop beats a simultaneous accept, so the burst counter must not see it either
  assign run_acc   = (state == RUN) && accept && !stop;
  assign last_xfer = (count + ONE) == len_q;

`ifdef DMUX_ADDR_SEQ_LOOP_EN
  assign burst_clr = ((state == IDLE) && start) || (run_acc && last_xfer);
`else
  assign burst_clr = (state == IDLE) && start;
`endif

  dmux_burst_cnt #(
    .W     (A),
    .BURST (BURST)
  ) u_burst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (burst_clr),
    .en    (run_acc),
    .wrap  (burst_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      sel    <= SEL_OUT2;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      len_q  <= '0;
      count  <= '0;
`ifdef DMUX_ADDR_SEQ_LOOP_EN
      base_q <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_q  <= len;
              count  <= '0;
              a      <= base;
              sel    <= SEL_OUT1;
              valid  <= 1'b1;
              busy   <= 1'b1;
              state  <= RUN;
`ifdef DMUX_ADDR_SEQ_LOOP_EN
              base_q <= base;
`endif
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          if (stop) begin
            // a/sel freeze on the aborted address; a coincident accept still counts
            if (accept) count <= count + ONE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (accept) begin
            if (last_xfer) begin
`ifdef DMUX_ADDR_SEQ_LOOP_EN
              count <= '0;
              a     <= base_q;
              sel   <= SEL_OUT1;
`else
              count <= count + ONE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`endif
            end else begin
              count <= count + ONE;
              a     <= a + ONE;
              if (burst_wrap) sel <= ~sel;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmux_addr_seq.sv
// Bench for dmux_addr_seq: table-driven sequences, randomized sequences against an
// index-based address/bank model, and hand-written reset corner cases.
module tb_dmux_addr_seq;

  localparam int A     = 8;
  localparam int D     = 8;
  localparam int BURST = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         stop;
  logic         ready;
  logic [A-1:0] base;
  logic [A-1:0] len;
  logic [A-1:0] a;
  logic         sel;
  logic         valid;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmux_addr_seq #(.A(A), .D(D), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .base  (base),
    .len   (len),
    .stop  (stop),
    .a     (a),
    .sel   (sel),
    .valid (valid),
    .ready (ready),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [A-1:0] b;
    logic [A-1:0] l;
    int           stall;
    int           stp;
    int           n;
    logic [A-1:0] ea;
    logic         es;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Position of transfer k inside the address range.
  function automatic int seq_idx(input int l, input int k);
`ifdef DMUX_ADDR_SEQ_LOOP_EN
    return (l == 0) ? k : (k % l);
`else
    return k;
`endif
  endfunction

  function automatic logic [A-1:0] model_a(input logic [A-1:0] b, input int l, input int k);
    int v;
    v = (int'(b) + seq_idx(l, k)) % (1 << A);
    return v[A-1:0];
  endfunction

  function automatic logic model_sel(input int l, input int k);
    return ((seq_idx(l, k) / BURST) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic run_seq(input logic [A-1:0] b, input logic [A-1:0] l, input int stall_idx,
                         input int stop_idx, input bit rnd, output int n_acc,
                         output logic [A-1:0] end_a, output logic end_sel);
    int k = 0;
    int last_k = -1;
    int stall_left = 3;
    int cyc = 0;
    bit fin = 0;
    bit acc;
    bit stp;
    n_acc   = 0;
    end_a   = '0;
    end_sel = 1'b0;
    base  = b;
    len   = l;
    start = 1'b1;
    stop  = 1'b0;
    ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base  = A'($urandom);
    len   = A'($urandom);
    while (!fin && cyc < 400) begin
      cyc++;
      if (done) begin
        fin = 1;
        check("done_busy", busy, 0);
        check("done_valid", valid, 0);
        if (last_k >= 0) begin
          check("end_a", a, model_a(b, int'(l), last_k));
          check("end_sel", sel, model_sel(int'(l), last_k));
        end
        end_a   = a;
        end_sel = sel;
      end else begin
        check("run_valid", valid, 1);
        check("run_busy", busy, 1);
        check("addr", a, model_a(b, int'(l), k));
        check("bank", sel, model_sel(int'(l), k));
        if (k == stall_idx && stall_left > 0) begin
          ready = 1'b0;
          stall_left--;
        end else if (rnd && k != stop_idx) begin
          ready = ($urandom_range(0, 2) != 0);
        end else begin
          ready = 1'b1;
        end
        stp    = (k == stop_idx);
        stop   = stp;
        acc    = valid && ready;
        last_k = k;
        @(posedge clk); #1;
        stop = 1'b0;
        if (acc) begin
          n_acc++;
          k++;
        end
        if (stp) check("stop_done", done, 1);
`ifndef DMUX_ADDR_SEQ_LOOP_EN
        if (acc && !stp && k == int'(l)) check("last_done", done, 1);
`endif
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL seq_timeout: got no done expected done within 400 cycles (base %0h len %0d)", b, l);
    end
    ready = 1'b1;
    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("idle_valid", valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           n;
    logic [A-1:0] ea;
    logic         es;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    ready = 1'b1;
    base  = '0;
    len   = '0;

`ifdef DMUX_ADDR_SEQ_LOOP_EN
    vecs.push_back(vec_t'{8'h20, 8'd2,  -1, 5, 6, 8'h21, 1'b1});
    vecs.push_back(vec_t'{8'h10, 8'd6,  -1, 8, 9, 8'h12, 1'b1});
    vecs.push_back(vec_t'{8'hFE, 8'd5,   3, 7, 8, 8'h00, 1'b1});
    vecs.push_back(vec_t'{8'h55, 8'd0,  -1, -1, 0, 8'h00, 1'b1});
`else
    vecs.push_back(vec_t'{8'h10, 8'd8,  -1, -1, 8, 8'h17, 1'b0});
    vecs.push_back(vec_t'{8'h10, 8'd8,   2, -1, 8, 8'h17, 1'b0});
    vecs.push_back(vec_t'{8'hFE, 8'd4,  -1, -1, 4, 8'h01, 1'b1});
    vecs.push_back(vec_t'{8'h10, 8'd8,  -1,  1, 2, 8'h11, 1'b1});
    vecs.push_back(vec_t'{8'h55, 8'd0,  -1, -1, 0, 8'h11, 1'b1});
    vecs.push_back(vec_t'{8'hF0, 8'd10, -1,  6, 7, 8'hF6, 1'b0});
    vecs.push_back(vec_t'{8'hFC, 8'd9,   3, -1, 9, 8'h04, 1'b1});
`endif

    // reset and idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stop = (i == 4);
      @(posedge clk); #1;
      check("reset_idle", {a, sel, valid, busy, done}, 0);
    end
    stop = 1'b0;

    foreach (vecs[i]) begin
      run_seq(vecs[i].b, vecs[i].l, vecs[i].stall, vecs[i].stp, 1'b0, n, ea, es);
      check($sformatf("vec%0d_count", i), n, vecs[i].n);
      check($sformatf("vec%0d_end_a", i), ea, vecs[i].ea);
      check($sformatf("vec%0d_end_sel", i), es, vecs[i].es);
    end

    for (int t = 0; t < 40; t++) begin
      logic [A-1:0] rb;
      int           rl;
      int           rs;
      int           en;
      rb = A'($urandom);
      rl = $urandom_range(0, 20);
`ifdef DMUX_ADDR_SEQ_LOOP_EN
      rs = (rl == 0) ? -1 : $urandom_range(0, 3 * rl);
      en = (rl == 0) ? 0 : rs + 1;
`else
      rs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rl) : -1;
      en = (rs >= 0 && rs < rl) ? rs + 1 : rl;
`endif
      run_seq(rb, A'(rl), -1, rs, 1'b1, n, ea, es);
      check("rand_count", n, en);
    end

    // asynchronous reset in the middle of a run
    base  = 8'h10;
    len   = 8'd8;
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_a", a, 8'h13);
    check("pre_reset_sel", sel, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {a, sel, valid, busy, done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_reset_quiet", {a, sel, valid, busy, done}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
